// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over valid/ready.
// Optional KEY_CACHE_EN: caches the 11 keys so they can be replayed later.
module aes_key_expand #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         replay,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [0:0] {
      S_IDLE,
      S_EMIT
   } state_t;

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // entry x sits at the (255-x)th byte from the LSB end
   function automatic logic [7:0] f_sbox(input logic [7:0] x);
      f_sbox = SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] f_rcon(input logic [3:0] i);
      case (i)
         4'd1:    f_rcon = 8'h01;
         4'd2:    f_rcon = 8'h02;
         4'd3:    f_rcon = 8'h04;
         4'd4:    f_rcon = 8'h08;
         4'd5:    f_rcon = 8'h10;
         4'd6:    f_rcon = 8'h20;
         4'd7:    f_rcon = 8'h40;
         4'd8:    f_rcon = 8'h80;
         4'd9:    f_rcon = 8'h1b;
         4'd10:   f_rcon = 8'h36;
         default: f_rcon = 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] f_expand(
      input logic [127:0] k,
      input logic [7:0]   rc
   );
      logic [31:0] w0, w1, w2, w3, rot, t;
      w0  = k[127:96];
      w1  = k[95:64];
      w2  = k[63:32];
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {f_sbox(rot[31:24]), f_sbox(rot[23:16]),
             f_sbox(rot[15:8]),  f_sbox(rot[7:0])};
      t   = t ^ {rc, 24'h0};
      w0  = w0 ^ t;
      w1  = w1 ^ w0;
      w2  = w2 ^ w1;
      w3  = w3 ^ w2;
      f_expand = {w0, w1, w2, w3};
   endfunction

   state_t       r_state;
   logic [127:0] r_rk;
   logic [3:0]   r_idx;
   logic         r_valid;
   logic         r_busy;
   logic         r_done;

   logic [3:0]   w_nidx;
   logic [127:0] w_exp;
   logic [127:0] w_next;
   logic         w_hs;

   assign w_nidx = r_idx + 4'd1;
   assign w_exp  = f_expand(r_rk, f_rcon(w_nidx));
   assign w_hs   = r_valid & rk_ready;

`ifdef KEY_CACHE_EN
   logic [127:0] r_cache [0:10];
   logic         r_cache_vld;
   logic         r_replay;

   assign w_next = r_replay ? r_cache[w_nidx] : w_exp;

   // each key lands at its own index as it is handed off
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_EMIT && w_hs)
         r_cache[r_idx] <= r_rk;
   end
`else
   logic w_unused_replay;

   assign w_unused_replay = replay;
   assign w_next          = w_exp;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rk    <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef KEY_CACHE_EN
         r_cache_vld <= 1'b0;
         r_replay    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_EMIT;
                  r_rk    <= key_in;
                  r_idx   <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef KEY_CACHE_EN
                  r_cache_vld <= 1'b0;
                  r_replay    <= 1'b0;
               end else if (replay && r_cache_vld) begin
                  r_state  <= S_EMIT;
                  r_rk     <= r_cache[0];
                  r_idx    <= '0;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_replay <= 1'b1;
`endif
               end
            end
            S_EMIT: begin
               if (w_hs) begin
                  if (r_idx == LAST) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
`ifdef KEY_CACHE_EN
                     r_cache_vld <= 1'b1;
`endif
                  end else begin
                     r_rk  <= w_next;
                     r_idx <= w_nidx;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rk       = r_rk;
   assign rk_idx   = r_idx;
   assign rk_valid = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: GF(2^8)-derived key-schedule model with a
// per-cycle compare process, plus FIPS-197 literal round keys.
module tb_aes_key_expand;

   typedef logic [127:0] ks_t [0:10];

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         replay;
   logic [127:0] rk;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [127:0] got [$];

   aes_key_expand dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .replay   (replay),
      .rk       (rk),
      .rk_idx   (rk_idx),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box from its definition: inverse in GF(2^8) then affine map
   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      if (a != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
             ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic ks_t expand_all(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      ks_t         ks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m(t[31:24]), sbox_m(t[23:16]),
                 sbox_m(t[15:8]), sbox_m(t[7:0])};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return ks;
   endfunction

   // Cycle model: predicts outputs after the next rising edge
   ks_t          mk;
   logic [127:0] m_rk;
   int           m_idx;
   bit           m_valid, m_busy, m_done, m_cv, m_known = 1'b0;

   always @(negedge clk) begin
      if (m_known) begin
         chk("rk_valid", 128'(rk_valid), 128'(m_valid));
         chk("busy", 128'(busy), 128'(m_busy));
         chk("done", 128'(done), 128'(m_done));
         chk("rk_idx", 128'(rk_idx), 128'(m_idx));
         chk("rk", rk, m_rk);
      end
      if (rst) begin
         m_rk    = '0;
         m_idx   = 0;
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_cv    = 1'b0;
         m_known = 1'b1;
      end else if (m_known) begin
         m_done = 1'b0;
         if (m_valid) begin
            if (rk_ready) begin
               got.push_back(rk);
               if (m_idx == 10) begin
                  m_valid = 1'b0;
                  m_busy  = 1'b0;
                  m_done  = 1'b1;
                  m_cv    = 1'b1;
               end else begin
                  m_idx++;
                  m_rk = mk[m_idx];
               end
            end
         end else if (start) begin
            mk      = expand_all(key_in);
            m_rk    = mk[0];
            m_idx   = 0;
            m_valid = 1'b1;
            m_busy  = 1'b1;
            m_cv    = 1'b0;
         end
`ifdef KEY_CACHE_EN
         else if (replay && m_cv) begin
            m_rk    = mk[0];
            m_idx   = 0;
            m_valid = 1'b1;
            m_busy  = 1'b1;
         end
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idx(input int k);
      for (int i = 0; i < 100; i++) begin
         if (rk_valid && rk_idx == 4'(k)) return;
         tick();
      end
      chk("wait_idx_timeout", 128'(rk_idx), 128'(k));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (done) return;
         tick();
      end
      chk("wait_done_timeout", 128'(done), 128'(1));
   endtask

   task automatic launch(input logic [127:0] k);
      got.delete();
      key_in = k;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic check_run(input string nm, input logic [127:0] i1,
                            input logic [127:0] i10);
      chk({nm, "_count"}, 128'(got.size()), 128'(11));
      if (got.size() == 11) begin
         chk({nm, "_idx1"}, got[1], i1);
         chk({nm, "_idx10"}, got[10], i10);
      end
   endtask

   initial begin
      ks_t ks;
      rst      = 1'b1;
      start    = 1'b0;
      key_in   = '0;
      replay   = 1'b0;
      rk_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      ks = expand_all(K1);
      chk("model_sbox00", 128'(sbox_m(8'h00)), 128'h63);
      chk("model_sbox53", 128'(sbox_m(8'h53)), 128'hed);
      chk("model_k1_idx1", ks[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("model_k1_idx10", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // full-throughput runs with both reference keys
      rk_ready = 1'b1;
      launch(K1);
      chk("first_idx0_key", rk, K1);
      wait_done();
      check_run("t1", 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      repeat (2) tick();
      launch(K2);
      wait_done();
      check_run("t2", 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5);
      tick();

      // random backpressure
      launch(K1);
      for (int i = 0; i < 400 && !done; i++) begin
         rk_ready = 1'($urandom_range(0, 1));
         tick();
      end
      rk_ready = 1'b1;
      chk("t3_done_seen", 128'(done), 128'(1));
      check_run("t3", 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();

      // start while busy is ignored; start in done cycle is taken
      launch(K2);
      wait_idx(4);
      key_in = K1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check_run("t4", 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5);
      launch(K1);
      chk("t4_restart_valid", 128'(rk_valid), 128'(1));
      chk("t4_restart_idx", 128'(rk_idx), 128'(0));
      wait_done();
      tick();

      // reset mid-run aborts
      launch(K1);
      wait_idx(6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", 128'(rk_valid), 128'(0));
      chk("t5_rk", rk, 128'h0);
      chk("t5_busy", 128'(busy), 128'(0));
      repeat (20) tick();

      // replay: honoured only with a valid cache
      launch(K1);
      wait_done();
      tick();
      got.delete();
      replay = 1'b1;
      tick();
      replay = 1'b0;
`ifdef KEY_CACHE_EN
      wait_done();
      check_run("t6_replay", 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
      repeat (15) tick();
      chk("t6_replay_ignored", 128'(got.size()), 128'(0));
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      got.delete();
      replay = 1'b1;
      tick();
      replay = 1'b0;
      repeat (15) tick();
      chk("t6_replay_after_rst", 128'(got.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
